// File: rtl/sram_arbiter.sv
// Two-port arbiter and cycle sequencer for an external asynchronous 16-bit SRAM.
// Each access runs IDLE -> SETUP -> STROBE (WAIT_CYCLES+1) -> DONE; simultaneous requests alternate.
module sram_arbiter #(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [1:0]        a_be,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [15:0]       a_wdata,
  output logic [15:0]       a_rdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [1:0]        b_be,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [15:0]       b_wdata,
  output logic [15:0]       b_rdata,
  output logic              b_ack,
  output logic [ADDR_W-1:0] SRAMaddr,
  output logic [15:0]       SRAMdout,
  input  logic [15:0]       SRAMdin,
  output logic              SRAMoe,
  output logic              SRAMce_n,
  output logic              SRAMwe_n,
  output logic              SRAMlb_n,
  output logic              SRAMub_n,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              gnt_b_q, gnt_b_d;
  logic              last_b_q, last_b_d;
  logic              we_q, we_d;
  logic [1:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [15:0]       a_rdata_q, a_rdata_d;
  logic [15:0]       b_rdata_q, b_rdata_d;
  logic              pick_b;

  // B wins only when A is idle or A was served last.
  assign pick_b = b_req && (!a_req || !last_b_q);

  always_comb begin
    state_d   = state_q;
    gnt_b_d   = gnt_b_q;
    last_b_d  = last_b_q;
    we_d      = we_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (a_req || b_req) begin
          gnt_b_d  = pick_b;
          last_b_d = pick_b;
          we_d     = pick_b ? b_we    : a_we;
          be_d     = pick_b ? b_be    : a_be;
          addr_d   = pick_b ? b_addr  : a_addr;
          wdata_d  = pick_b ? b_wdata : a_wdata;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = 4'(WAIT_CYCLES);
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          if (!we_q) begin
            if (gnt_b_q) b_rdata_d = SRAMdin;
            else         a_rdata_d = SRAMdin;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      gnt_b_q   <= 1'b0;
      last_b_q  <= 1'b1;
      we_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_b_q   <= gnt_b_d;
      last_b_q  <= last_b_d;
      we_q      <= we_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  // Pin controls decode straight from the async-reset state so reset releases them immediately.
  always_comb begin
    busy     = (state_q != S_IDLE);
    SRAMce_n = !busy;
    SRAMwe_n = !((state_q == S_STROBE) && we_q);
    SRAMoe   = busy && we_q;
    SRAMlb_n = busy ? !be_q[0] : 1'b1;
    SRAMub_n = busy ? !be_q[1] : 1'b1;
    a_ack    = (state_q == S_DONE) && !gnt_b_q;
    b_ack    = (state_q == S_DONE) && gnt_b_q;
    SRAMaddr = addr_q;
    SRAMdout = wdata_q;
    a_rdata  = a_rdata_q;
    b_rdata  = b_rdata_q;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural async SRAM on the bus (WAIT_CYCLES=1).
module tb_sram_arbiter;
  localparam int unsigned AW = 18;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, a_we, b_req, b_we;
  logic [1:0]    a_be, b_be;
  logic [AW-1:0] a_addr, b_addr;
  logic [15:0]   a_wdata, b_wdata, a_rdata, b_rdata;
  logic          a_ack, b_ack;
  logic [AW-1:0] SRAMaddr;
  logic [15:0]   SRAMdout, SRAMdin;
  logic          SRAMoe, SRAMce_n, SRAMwe_n, SRAMlb_n, SRAMub_n, busy;

  sram_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_ack(b_ack),
    .SRAMaddr(SRAMaddr), .SRAMdout(SRAMdout), .SRAMdin(SRAMdin), .SRAMoe(SRAMoe),
    .SRAMce_n(SRAMce_n), .SRAMwe_n(SRAMwe_n), .SRAMlb_n(SRAMlb_n), .SRAMub_n(SRAMub_n),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Async SRAM: data committed on the rising edge of the write strobe.
  logic [15:0] mem [0:255];
  assign SRAMdin = (!SRAMce_n && !SRAMoe) ? mem[SRAMaddr[7:0]] : 16'h0000;
  always @(posedge SRAMwe_n) begin
    if (SRAMce_n == 1'b0 && SRAMoe == 1'b1) begin
      if (!SRAMlb_n) mem[SRAMaddr[7:0]][7:0]  = SRAMdout[7:0];
      if (!SRAMub_n) mem[SRAMaddr[7:0]][15:8] = SRAMdout[15:8];
    end
  end

  typedef struct { bit side; bit rd; logic [15:0] data; } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pins"}, {27'd0, SRAMce_n, SRAMwe_n, SRAMlb_n, SRAMub_n, SRAMoe}, 32'h1E);
    chk({tag, "_addr"}, {14'd0, SRAMaddr}, 32'd0);
    chk({tag, "_dout"}, {16'd0, SRAMdout}, 32'd0);
    chk({tag, "_rdata"}, {a_rdata, b_rdata}, 32'd0);
    chk({tag, "_ack_busy"}, {29'd0, a_ack, b_ack, busy}, 32'd0);
  endtask

  task automatic access(input bit side, input bit we, input logic [1:0] be,
                        input logic [AW-1:0] addr, input logic [15:0] wd,
                        input logic [15:0] exp_rd,
                        output int ack_c, output int we_c, output int oe_c, output int lane_c);
    exp_q.push_back('{side, !we, exp_rd});
    if (side) begin
      b_we = we; b_be = be; b_addr = addr; b_wdata = wd; b_req = 1'b1;
    end else begin
      a_we = we; a_be = be; a_addr = addr; a_wdata = wd; a_req = 1'b1;
    end
    ack_c = -1; we_c = 0; oe_c = 0; lane_c = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!SRAMwe_n) we_c++;
      if (SRAMoe) oe_c++;
      if (!SRAMlb_n || !SRAMub_n) lane_c++;
      if (side ? b_ack : a_ack) begin
        ack_c = n;
        break;
      end
    end
    if (ack_c < 0) begin
      checks++; errors++;
      $display("FAIL ack_timeout: got no ack expected ack within 40 cycles");
    end
    @(posedge clk); #1;
    if (side) b_req = 1'b0; else a_req = 1'b0;
  endtask

  int ack_c, we_c, oe_c, lane_c;
  int t_ack [4];
  int nack;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    reset = 1'b1;
    a_req = 0; a_we = 0; a_be = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_be = 0; b_addr = '0; b_wdata = '0;

    fork
      forever begin : monitor
        exp_t e;
        @(negedge clk);
        if (!reset && (a_ack || b_ack)) begin
          chk("single_ack", {31'd0, a_ack & b_ack}, 32'd0);
          chk("ack_expected", {31'd0, exp_q.size() > 0}, 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ack_side", {31'd0, b_ack}, {31'd0, e.side});
            if (e.rd) chk("rdata", {16'd0, e.side ? b_rdata : a_rdata}, {16'd0, e.data});
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b0;
    @(posedge clk); #1;

    // A write BEEF, full lanes
    access(1'b0, 1'b1, 2'b11, 18'h00010, 16'hBEEF, 16'h0, ack_c, we_c, oe_c, lane_c);
    chk("wr_ack_cycle", ack_c, 4);
    chk("wr_we_cycles", we_c, 2);
    chk("wr_oe_cycles", oe_c, 4);
    chk("wr_mem", {16'd0, mem[16]}, 32'hBEEF);
    chk("idle_oe_busy", {30'd0, SRAMoe, busy}, 32'd0);

    // A read back
    access(1'b0, 1'b0, 2'b11, 18'h00010, 16'h0, 16'hBEEF, ack_c, we_c, oe_c, lane_c);
    chk("rd_ack_cycle", ack_c, 4);
    chk("rd_oe_cycles", oe_c, 0);
    chk("rd_we_cycles", we_c, 0);

    // Low-byte write, then read merged word
    access(1'b0, 1'b1, 2'b01, 18'h00010, 16'h1234, 16'h0, ack_c, we_c, oe_c, lane_c);
    access(1'b0, 1'b0, 2'b11, 18'h00010, 16'h0, 16'hBE34, ack_c, we_c, oe_c, lane_c);

    // No-lane write: full cycle, ack, no data change
    access(1'b0, 1'b1, 2'b00, 18'h00010, 16'hFFFF, 16'h0, ack_c, we_c, oe_c, lane_c);
    chk("be00_ack_cycle", ack_c, 4);
    chk("be00_lane_cycles", lane_c, 0);
    access(1'b0, 1'b0, 2'b11, 18'h00010, 16'h0, 16'hBE34, ack_c, we_c, oe_c, lane_c);

    // B write, reset during STROBE, held request completes afterwards
    exp_q.push_back('{1'b1, 1'b0, 16'h0});
    b_we = 1'b1; b_be = 2'b11; b_addr = 18'h00030; b_wdata = 16'h5555; b_req = 1'b1;
    begin : wait_strobe
      for (int n = 0; n < 10; n++) begin
        @(negedge clk);
        if (!SRAMwe_n) disable wait_strobe;
      end
      checks++; errors++;
      $display("FAIL strobe_timeout: got no strobe expected strobe within 10 cycles");
    end
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    ack_c = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (b_ack) begin ack_c = n; break; end
    end
    chk("rst_retry_ack_cycle", ack_c, 4);
    @(posedge clk); #1;
    b_req = 1'b0;
    access(1'b1, 1'b0, 2'b11, 18'h00030, 16'h0, 16'h5555, ack_c, we_c, oe_c, lane_c);
    chk("b_rd_ack_cycle", ack_c, 4);

    // Both requesters held continuously: alternation starting with A
    exp_q.push_back('{1'b0, 1'b1, 16'hBE34});
    exp_q.push_back('{1'b1, 1'b1, 16'h5555});
    exp_q.push_back('{1'b0, 1'b1, 16'hBE34});
    exp_q.push_back('{1'b1, 1'b1, 16'h5555});
    a_we = 1'b0; a_be = 2'b11; a_addr = 18'h00010;
    b_we = 1'b0; b_be = 2'b11; b_addr = 18'h00030;
    a_req = 1'b1; b_req = 1'b1;
    nack = 0;
    for (int n = 0; n < 60 && nack < 4; n++) begin
      @(negedge clk);
      if (a_ack || b_ack) begin
        t_ack[nack] = n;
        nack++;
      end
    end
    @(posedge clk); #1;
    a_req = 1'b0; b_req = 1'b0;
    chk("arb_ack_count", nack, 4);
    if (nack == 4) begin
      chk("arb_first_ack", t_ack[0], 4);
      for (int i = 1; i < 4; i++) chk("arb_spacing", t_ack[i] - t_ack[i-1], 5);
    end

    repeat (4) @(negedge clk);
    chk("pending_expect", exp_q.size(), 0);
    chk("final_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
